// File: rtl/fir_ctrl_pkg.sv
// Shared types and width helpers for the FIR frame sequencer.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    localparam int FIR_DATA_WL = 12;

    // Entry layout at the default sample width; the FIFO stores
    // the same {last, data} packing at whatever DATA_WL is built.
    typedef struct packed {
        logic                   last;
        logic [FIR_DATA_WL-1:0] data;
    } fifo_entry_t;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int flush_cnt_w(input int taps);
        return $clog2(taps);
    endfunction

    function automatic int out_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; async active-low reset.
module fir_sample_fifo
    import fir_ctrl_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int CNT_W = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer in front of the FIR: issue, zero-flush, drain, delimit.
// FIR_CTRL_TIMEOUT_EN adds a DRAIN watchdog with a sticky err output.
module fir_frame_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_WL         = 12,
    parameter int NUM_TAPS        = 30,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 64
`ifdef FIR_CTRL_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC     = 256
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_WL-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATA_WL-1:0] fir_data_in,
    output logic               fir_in_valid,
    input  logic [DATA_WL-1:0] fir_data_out,
    input  logic               fir_out_valid,
    output logic [DATA_WL-1:0] m_data,
    output logic               m_valid,
    output logic               m_last,
    output logic               busy
`ifdef FIR_CTRL_TIMEOUT_EN
   ,output logic               err
`endif
);

    localparam int QCNT_W = fifo_cnt_w(FIFO_DEPTH);
    localparam int FCNT_W = flush_cnt_w(NUM_TAPS);
    localparam int OCNT_W = out_cnt_w(MAX_OUTSTANDING);
    localparam int ENT_W  = DATA_WL + 1;

    localparam logic [FCNT_W-1:0] FLUSH_LAST =
        FCNT_W'(NUM_TAPS - 2);
    localparam logic [QCNT_W-1:0] FIFO_FULL =
        QCNT_W'(FIFO_DEPTH);
    localparam logic [OCNT_W-1:0] OUT_ONE = OCNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FCNT_W-1:0]   r_flush_cnt;
    logic [FCNT_W-1:0]   w_flush_nxt;
    logic [OCNT_W-1:0]   r_outstanding;
    logic [OCNT_W-1:0]   w_out_nxt;
    logic                r_fir_in_valid;
    logic                w_in_valid_nxt;
    logic [DATA_WL-1:0]  r_fir_data_in;
    logic [DATA_WL-1:0]  w_data_nxt;
    logic                r_rdy_en;
    logic [DATA_WL-1:0]  r_m_data;
    logic                r_m_valid;
    logic                r_m_last;

    logic                w_push;
    logic                w_pop;
    logic [ENT_W-1:0]    w_push_ent;
    logic [ENT_W-1:0]    w_head;
    logic                w_head_last;
    logic [DATA_WL-1:0]  w_head_data;
    logic [QCNT_W-1:0]   w_fifo_cnt;
    logic                w_empty;
    logic                w_full;
    logic                w_out_acc;
    logic                w_last_hit;
    logic                w_timeout;

    assign w_empty     = (w_fifo_cnt == '0);
    assign w_full      = (w_fifo_cnt == FIFO_FULL);
    assign s_ready     = r_rdy_en && !w_full;
    assign w_push      = s_valid && s_ready;
    assign w_push_ent  = {s_last, s_data};
    assign w_head_last = w_head[DATA_WL];
    assign w_head_data = w_head[DATA_WL-1:0];

    fir_sample_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (QCNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_ent),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_cnt)
    );

    // Results with nothing in flight are stale (e.g. from before reset).
    assign w_out_acc  = fir_out_valid && (r_outstanding != '0);
    assign w_last_hit = w_out_acc && (r_state == DRAIN) &&
                        (r_outstanding == OUT_ONE) &&
                        !r_fir_in_valid;

`ifdef FIR_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = (r_state == DRAIN) && (r_to_cnt == TO_LIMIT);
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != DRAIN || fir_out_valid) begin
                r_to_cnt <= '0;
            end else if (!w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_flush_nxt    = r_flush_cnt;
        w_pop          = 1'b0;
        w_in_valid_nxt = 1'b0;
        w_data_nxt     = '0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_in_valid_nxt = 1'b1;
                    w_data_nxt     = w_head_data;
                    if (w_head_last) begin
                        w_state_nxt = FLUSH;
                        w_flush_nxt = '0;
                    end
                end
            end
            FLUSH: begin
                w_in_valid_nxt = 1'b1;
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_flush_nxt = r_flush_cnt + 1'b1;
                end
            end
            DRAIN: begin
                // The final flush strobe is still on the wire in the
                // first DRAIN cycle and is not yet counted.
                if (r_outstanding == '0 && !r_fir_in_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_out_nxt = r_outstanding;
        if (r_fir_in_valid && !w_out_acc) begin
            w_out_nxt = r_outstanding + 1'b1;
        end else if (!r_fir_in_valid && w_out_acc) begin
            w_out_nxt = r_outstanding - 1'b1;
        end
        if (w_timeout) begin
            w_out_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_flush_cnt    <= '0;
            r_outstanding  <= '0;
            r_fir_in_valid <= 1'b0;
            r_fir_data_in  <= '0;
            r_rdy_en       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_flush_cnt    <= w_flush_nxt;
            r_outstanding  <= w_out_nxt;
            r_fir_in_valid <= w_in_valid_nxt;
            r_fir_data_in  <= w_data_nxt;
            r_rdy_en       <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            r_m_valid <= w_out_acc;
            r_m_last  <= w_last_hit;
            if (w_out_acc) begin
                r_m_data <= fir_data_out;
            end
        end
    end

    assign fir_data_in  = r_fir_data_in;
    assign fir_in_valid = r_fir_in_valid;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign m_last       = r_m_last;
    assign busy         = (r_state != IDLE);

endmodule
